// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the prefetching fetch unit.
package ifu_pkg;

    localparam int IFU_XLEN = 32;
    localparam int INST_BYTES = 4;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FAULT
    } state_t;

    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [IFU_XLEN-1:0] inst;
        logic                fault;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// ifu_fetch_fifo: synchronous FIFO of fetched entries with count and flush.
module ifu_fetch_fifo
    import ifu_pkg::*;
#(
    parameter int W = $bits(fetch_entry_t),
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Storage carries no reset; the read side is gated by empty.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: streaming instruction prefetch over AXI-lite reads with
// credit-limited issue, redirect flush and stale-response discard.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int XLEN = IFU_XLEN,
    parameter int DEPTH = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ifu_send_valid,
    input  logic            ifu_receive_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [XLEN-1:0] rdata,
    input  logic            rvalid,
    input  logic [1:0]      rresp,
    output logic            rready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = CW + 1;
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            fault;
    } entry_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_nxt;
    logic            ar_stale;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   out_nxt;
    logic [OW-1:0]   drop_cnt;
    logic [OW-1:0]   drop_nxt;
    logic [XLEN-1:0] pcq [MAX_OUTSTANDING];
    logic [QW-1:0]   pq_wr;
    logic [QW-1:0]   pq_rd;

    logic            ar_hs;
    logic            r_hs;
    logic            drop_hit;
    logic            stale_hs;
    logic            push;
    logic            push_fault;
    logic            pop;
    logic            issue;
    logic [SW-1:0]   occ;

    entry_t          new_entry;
    entry_t          head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    function automatic logic [QW-1:0] pq_inc(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ar_hs      = arvalid && arready;
    assign r_hs       = rvalid && rready;
    assign drop_hit   = r_hs && (drop_cnt != '0);
    assign stale_hs   = ar_hs && ar_stale;
    assign push       = r_hs && !drop_hit && !redirect_valid;
    assign push_fault = push && (rresp != RESP_OKAY);
    assign pop        = ifu_send_valid && ifu_receive_ready;

    assign new_entry.pc    = pcq[pq_rd];
    assign new_entry.inst  = rdata;
    assign new_entry.fault = (rresp != RESP_OKAY);

    always_comb begin
        out_nxt = outstanding;
        if (ar_hs && !r_hs)
            out_nxt = outstanding + 1'b1;
        else if (!ar_hs && r_hs)
            out_nxt = outstanding - 1'b1;
    end

    always_comb begin
        drop_nxt = drop_cnt;
        if (stale_hs && !drop_hit)
            drop_nxt = drop_cnt + 1'b1;
        else if (!stale_hs && drop_hit)
            drop_nxt = drop_cnt - 1'b1;
    end

    always_comb begin
        fetch_pc_nxt = fetch_pc;
        unique case (1'b1)
            redirect_valid:
                fetch_pc_nxt = redirect_pc & ~XLEN'(INST_BYTES - 1);
            ar_hs && !ar_stale:
                fetch_pc_nxt = fetch_pc + XLEN'(INST_BYTES);
            default: ;
        endcase
    end

    // Every slot counts: queued entries, replies in flight, and the AR
    // completing now, so a reply can never find the FIFO full.
    assign occ = SW'(fifo_count) + SW'(outstanding) + SW'(ar_hs);

    assign issue = (state != FAULT) && !push_fault && !redirect_valid
                && (!arvalid || ar_hs) && !fifo_full
                && (occ < SW'(DEPTH))
                && (out_nxt < OW'(MAX_OUTSTANDING));

    always_ff @(posedge clk) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (push_fault) state_nxt = FAULT;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = BOOT;
        endcase
        if (redirect_valid) state_nxt = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            arvalid     <= 1'b0;
            araddr      <= '0;
            ar_stale    <= 1'b0;
            rready      <= 1'b0;
            outstanding <= '0;
            drop_cnt    <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
        end else begin
            fetch_pc    <= fetch_pc_nxt;
            rready      <= 1'b1;
            outstanding <= out_nxt;
            drop_cnt    <= redirect_valid ? out_nxt : drop_nxt;
            if (ar_hs) pq_wr <= pq_inc(pq_wr);
            if (r_hs)  pq_rd <= pq_inc(pq_rd);
            if (issue) begin
                arvalid  <= 1'b1;
                araddr   <= fetch_pc_nxt;
                ar_stale <= 1'b0;
            end else if (ar_hs) begin
                arvalid  <= 1'b0;
                ar_stale <= 1'b0;
            end else if (redirect_valid && arvalid) begin
                ar_stale <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ar_hs)
            pcq[pq_wr] <= araddr;
    end

    ifu_fetch_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   (new_entry),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ifu_send_valid = !fifo_empty;
    assign instruction    = fifo_empty ? '0 : head.inst;
    assign inst_pc        = fifo_empty ? '0 : head.pc;
    assign inst_fault     = !fifo_empty && head.fault;

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed checks of ifu_prefetch against a simple
// AXI-lite read memory with programmable latency and fault address.
module tb_ifu_prefetch;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ifu_send_valid;
    logic        ifu_receive_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0;
    logic [1:0]  rresp = '0;
    logic        rready;

    always #5 clk = ~clk;

    ifu_prefetch dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .ifu_send_valid    (ifu_send_valid),
        .ifu_receive_ready (ifu_receive_ready),
        .instruction       (instruction),
        .inst_pc           (inst_pc),
        .inst_fault        (inst_fault),
        .araddr            (araddr),
        .arvalid           (arvalid),
        .arready           (arready),
        .rdata             (rdata),
        .rvalid            (rvalid),
        .rresp             (rresp),
        .rready            (rready)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$],
                                         input int i);
        if (i < q.size()) return q[i];
        return 32'hdead_beef;
    endfunction

    logic [31:0] mq_addr[$];
    int          mq_t[$];
    logic [31:0] ar_log[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_inst[$];
    logic [31:0] del_flt[$];
    int          cyc = 0;
    int          lat = 1;
    logic        ar_block = 1'b0;
    logic [31:0] fault_addr = 32'hffff_ffff;
    int          outb = 0;

    // Memory drives at negedge, then logs handshakes just before posedge.
    always @(negedge clk) begin
        cyc++;
        arready = !ar_block;
        if (mq_addr.size() > 0 && mq_t[0] + lat <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_word(mq_addr[0]);
            rresp  = (mq_addr[0] == fault_addr) ? 2'b10 : 2'b00;
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
            rresp  = '0;
        end
        #4;
        if (rst) begin
            mq_addr.delete();
            mq_t.delete();
            outb = 0;
        end else begin
            if (arvalid && arready) begin
                mq_addr.push_back(araddr);
                mq_t.push_back(cyc);
                ar_log.push_back(araddr);
                outb++;
            end
            if (rvalid && rready) begin
                void'(mq_addr.pop_front());
                void'(mq_t.pop_front());
                outb--;
            end
            if (ifu_send_valid && ifu_receive_ready) begin
                del_pc.push_back(inst_pc);
                del_inst.push_back(instruction);
                del_flt.push_back({31'd0, inst_fault});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        step(2);
        ar_log.delete();
        del_pc.delete();
        del_inst.delete();
        del_flt.delete();
        rst = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    int          n;
    int          n0;
    int          a0;
    logic        got;
    logic [31:0] a_pend;

    initial begin
        // 1: streaming after reset, 1-cycle memory
        lat = 1;
        ifu_receive_ready = 1'b1;
        do_reset();
        @(posedge clk); #1;
        check("t1_arvalid", {31'd0, arvalid}, 32'd1);
        check("t1_araddr", araddr, RPC);
        n = 1;
        while (!ifu_send_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("t1_latency", n, 32'd3);
        step(10);
        check("t1_ar0", qget(ar_log, 0), RPC);
        check("t1_ar1", qget(ar_log, 1), RPC + 4);
        check("t1_ar2", qget(ar_log, 2), RPC + 8);
        check("t1_pc0", qget(del_pc, 0), RPC);
        check("t1_pc2", qget(del_pc, 2), RPC + 8);
        check("t1_inst1", qget(del_inst, 1), mem_word(RPC + 4));

        // 2: IDU stalled fills the FIFO, then drains in order
        ifu_receive_ready = 1'b0;
        do_reset();
        step(20);
        check("t2_ar_count", ar_log.size(), 32'd4);
        check("t2_arvalid", {31'd0, arvalid}, 32'd0);
        check("t2_valid", {31'd0, ifu_send_valid}, 32'd1);
        check("t2_head_pc", inst_pc, RPC);
        ifu_receive_ready = 1'b1;
        step(20);
        for (int i = 0; i < 4; i++)
            check("t2_order", qget(del_pc, i), RPC + 32'(4 * i));
        check("t2_resume", qget(ar_log, 4), RPC + 32'h10);

        // 3: redirect with two requests outstanding
        lat = 4;
        do_reset();
        for (int i = 0; i < 30 && outb != 2; i++) @(negedge clk);
        check("t3_outstanding", outb, 32'd2);
        pulse_redirect(32'h8000_1002);
        n0 = del_pc.size();
        a0 = ar_log.size();
        step(30);
        check("t3_ar", qget(ar_log, a0), 32'h8000_1000);
        check("t3_pc0", qget(del_pc, n0), 32'h8000_1000);
        check("t3_inst0", qget(del_inst, n0), mem_word(32'h8000_1000));
        check("t3_pc1", qget(del_pc, n0 + 1), 32'h8000_1004);

        // 4: redirect while an AR is held off by arready
        lat = 2;
        do_reset();
        step(6);
        @(posedge clk); #1;
        ar_block = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (arvalid && !arready) begin
                got = 1'b1;
                break;
            end
        end
        check("t4_pending", {31'd0, got}, 32'd1);
        a_pend = araddr;
        pulse_redirect(32'h8000_2000);
        n0 = del_pc.size();
        a0 = ar_log.size();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t4_hold_addr", araddr, a_pend);
            check("t4_hold_valid", {31'd0, arvalid}, 32'd1);
        end
        ar_block = 1'b0;
        step(30);
        check("t4_stale_ar", qget(ar_log, a0), a_pend);
        check("t4_next_ar", qget(ar_log, a0 + 1), 32'h8000_2000);
        check("t4_pc0", qget(del_pc, n0), 32'h8000_2000);

        // 5: faulting second response, trailing reply still delivered
        lat = 3;
        fault_addr = RPC + 4;
        do_reset();
        step(30);
        check("t5_ar_count", ar_log.size(), 32'd3);
        check("t5_del_count", del_pc.size(), 32'd3);
        check("t5_flt0", qget(del_flt, 0), 32'd0);
        check("t5_flt1", qget(del_flt, 1), 32'd1);
        check("t5_pc1", qget(del_pc, 1), RPC + 4);
        check("t5_flt2", qget(del_flt, 2), 32'd0);
        check("t5_pc2", qget(del_pc, 2), RPC + 8);
        check("t5_arvalid", {31'd0, arvalid}, 32'd0);
        @(posedge clk); #1;
        fault_addr = 32'hffff_ffff;
        @(negedge clk);
        a0 = ar_log.size();
        pulse_redirect(32'h8000_3000);
        step(10);
        check("t5_recover", qget(ar_log, a0), 32'h8000_3000);

        // 6: reset in the middle of traffic
        lat = 3;
        ifu_receive_ready = 1'b0;
        do_reset();
        step(8);
        check("t6_busy", {31'd0, ifu_send_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_valid", {31'd0, ifu_send_valid}, 32'd0);
        check("t6_inst", instruction, 32'd0);
        check("t6_pc", inst_pc, 32'd0);
        check("t6_fault", {31'd0, inst_fault}, 32'd0);
        check("t6_araddr", araddr, 32'd0);
        check("t6_arvalid", {31'd0, arvalid}, 32'd0);
        check("t6_rready", {31'd0, rready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_rel_arvalid", {31'd0, arvalid}, 32'd1);
        check("t6_rel_araddr", araddr, RPC);
        check("t6_rel_rready", {31'd0, rready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Parametrised successor to the single-shot fetch unit. It streams sequential instruction fetches over an AXI-lite read channel, with up to MAX_OUTSTANDING requests in flight, into a DEPTH-entry prefetch FIFO. It hands instructions to the IDU over the existing valid/ready handshake. It also supports redirect (flush), error tagging and stale-response discard, and sits between the PC/redirect logic and the IDU.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered AR requests (1..DEPTH)
RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  XLEN  new fetch address; bits [1:0] are ignored (treated as 0)
ifu_send_valid  out  1  FIFO head valid toward IDU
ifu_receive_ready  in  1  IDU accepts head
instruction  out  XLEN  head instruction word
inst_pc  out  XLEN  address of head instruction
inst_fault  out  1  head fetched with rresp != 0
araddr  out  XLEN  AR address
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  XLEN  R data
rvalid  in  1  R valid
rresp  in  2  R response (0 = OKAY)
rready  out  1  R ready

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs 0 and the FIFO empty.
  - outstanding=0, drop_cnt=0, fetch_pc=RESET_PC, state=BOOT.
- rready is registered: 0 during reset, 1 on every cycle after. Credit reservation guarantees every response has a slot.
- States:
  - BOOT: transitions to RUN on the first cycle after reset.
  - RUN: issues fetches.
  - FAULT: no new AR issued; waits for redirect.
  - Any state goes to RUN on redirect_valid.
- Issue rule: in RUN, with no AR pending, arvalid rises on the next cycle with araddr=fetch_pc when both hold:
  - fifo_count + outstanding < DEPTH
  - outstanding < MAX_OUTSTANDING
- AR hold: once arvalid=1, arvalid and araddr stay stable until arvalid&&arready. On that cycle, fetch_pc += 4 and outstanding += 1.
- Latency:
  - First arvalid appears 1 cycle after rst falls.
  - A response accepted in cycle t is visible at the FIFO head at t+1 (if the FIFO was empty).
- Response acceptance (rvalid&&rready): outstanding -= 1.
  - If drop_cnt > 0: the response is discarded and drop_cnt -= 1.
  - Otherwise it is enqueued as {pc, rdata, fault=(rresp!=0)}. The entry pc is tracked in an in-order pc queue written at AR handshake.
- Fault: enqueuing a faulting entry moves RUN to FAULT. Responses that are still outstanding are still accepted and enqueued. The faulting entry is delivered to the IDU normally.
- Simultaneous AR handshake and R handshake in the same cycle: outstanding is unchanged.
- IDU handshake (ifu_send_valid&&ifu_receive_ready): the FIFO is popped. Simultaneous push and pop are allowed at full and at empty. Bypass is not allowed: an empty FIFO shows valid only on the next cycle.
- Redirect (highest priority, takes effect at the clock edge):
  - FIFO cleared; an IDU handshake in the same cycle still counts as consumed.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; state <= RUN.
  - drop_cnt <= outstanding_next, i.e. including any AR handshaking or R arriving this cycle. An R arriving in the redirect cycle itself is dropped, not counted.
  - An AR still pending (arvalid=1, no arready) stays asserted with its old address and is marked stale. Its later handshake increments drop_cnt as well as outstanding.
  - Fetch at the new pc starts only after the stale AR completes.
- Redirect during reset: ignored (reset wins).
- Back-to-back redirects: each recomputes drop_cnt from the current outstanding count.
- ifu_send_valid, instruction, inst_pc and inst_fault are driven from registered FIFO head state only. There is no combinational path from any input.

Decomposition:
- Package ifu_pkg:
  - state enum {BOOT, RUN, FAULT}
  - fetch entry struct {pc, inst, fault}
  - RESP_OKAY=2'b00
  - INST_BYTES=4
- One natural sub-module: ifu_fetch_fifo, a parametrised synchronous FIFO of entries with count, push/pop/flush and full/empty. The top level holds the FSM, credit/outstanding/drop counters and the pc queue.

Test Plan:
1. Reset release, memory answers each AR 1 cycle later with OKAY, IDU always ready -> araddr sequence 0x80000000, 0x80000004, 0x80000008; inst_pc matches; first ifu_send_valid 3 cycles after rst falls.
2. IDU ready held 0, DEPTH=4 -> exactly 4 AR handshakes, then arvalid stays 0. Ready raised -> 4 entries delivered in order, fetch resumes at 0x80000010.
3. Redirect to 0x80001002 while 2 requests are outstanding -> both responses discarded (drop_cnt 2->0). The next AR is at 0x80001000; the first delivered inst_pc is 0x80001000.
4. Redirect while arvalid is pending and arready is held low 3 cycles -> araddr stays unchanged until arready; the stale response is dropped; the next araddr is the redirect target.
5. Second response returns rresp=2'b10 -> the entry is delivered with inst_fault=1; no further AR issues until redirect; the trailing outstanding response is still delivered.
6. rst asserted with 2 outstanding and 3 FIFO entries -> next cycle all outputs 0; after release arvalid=1 with araddr=RESET_PC.
